// File: rtl/dac_slew_if.sv
// Target handshake and output bundle between the SPGD controller, the slew limiter
// and the DAC_offset_to_twos stage. All codes are offset binary.
interface dac_slew_if #(
  parameter int WIRE_WIDTH = 14
);
  logic [WIRE_WIDTH-1:0] target_in;
  logic                  target_valid;
  logic                  target_ready;
  logic [WIRE_WIDTH-1:0] data_out;
  logic                  update;
  logic                  settled;

  modport master (
    output target_in, target_valid,
    input  target_ready, data_out, update, settled
  );

  modport slave (
    input  target_in, target_valid,
    output target_ready, data_out, update, settled
  );
endinterface

// File: rtl/dac_slew_limiter.sv
// Rate-limiting register stage in front of DAC_offset_to_twos: clamps accepted targets to
// [lim_lo, lim_hi] and walks data_out toward the goal by at most max_step per tick.
module dac_slew_limiter #(
  parameter int WIRE_WIDTH = 14,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  dac_slew_if.slave             bus,
  input  logic [WIRE_WIDTH-1:0] max_step,
  input  logic [DIV_WIDTH-1:0]  tick_div,
  input  logic [WIRE_WIDTH-1:0] lim_lo,
  input  logic [WIRE_WIDTH-1:0] lim_hi
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SLEW = 1'b1;
  localparam logic [WIRE_WIDTH-1:0] MIDSCALE = {1'b1, {(WIRE_WIDTH-1){1'b0}}};

  // An inverted window collapses onto lim_lo.
  function automatic logic [WIRE_WIDTH-1:0] clamp_code(
    input logic [WIRE_WIDTH-1:0] t,
    input logic [WIRE_WIDTH-1:0] lo,
    input logic [WIRE_WIDTH-1:0] hi
  );
    if (lo > hi)     return lo;
    else if (t < lo) return lo;
    else if (t > hi) return hi;
    else             return t;
  endfunction

  // One bounded move toward goal; the result always lies between cur and goal.
  function automatic logic [WIRE_WIDTH-1:0] slew_step(
    input logic [WIRE_WIDTH-1:0] cur,
    input logic [WIRE_WIDTH-1:0] goal,
    input logic [WIRE_WIDTH-1:0] step
  );
    logic signed [WIRE_WIDTH:0] d;
    logic        [WIRE_WIDTH:0] mag;
    d   = $signed({1'b0, goal}) - $signed({1'b0, cur});
    mag = (d < 0) ? $unsigned(-d) : $unsigned(d);
    if (mag <= {1'b0, step}) return goal;
    else if (d > 0)          return cur + step;
    else                     return cur - step;
  endfunction

  logic [0:0]            state_p0, state_nxt;
  logic [DIV_WIDTH-1:0]  cnt_p0, cnt_nxt;
  logic [WIRE_WIDTH-1:0] goal_p0, goal_nxt;
  logic [WIRE_WIDTH-1:0] out_p0, out_nxt;
  logic                  upd_p0;
  logic                  settled_p0;

  logic [WIRE_WIDTH-1:0] step_eff;
  logic [WIRE_WIDTH-1:0] goal_in;
  logic                  tick;
  logic                  accept;

  assign bus.target_ready = ~rst;
  assign bus.data_out     = out_p0;
  assign bus.update       = upd_p0;
  assign bus.settled      = settled_p0;

  always_comb begin
    step_eff  = (max_step == '0) ? WIRE_WIDTH'(1) : max_step;
    accept    = bus.target_valid & ~rst;
    goal_in   = clamp_code(bus.target_in, lim_lo, lim_hi);
    tick      = (state_p0 == SLEW) && (cnt_p0 == tick_div);
    // A tick coinciding with an acceptance still steps toward the old goal.
    out_nxt   = tick ? slew_step(out_p0, goal_p0, step_eff) : out_p0;
    goal_nxt  = accept ? goal_in : goal_p0;
    state_nxt = state_p0;
    cnt_nxt   = '0;
    if (state_p0 == IDLE) begin
      if (accept && (goal_in != out_p0)) state_nxt = SLEW;
    end else begin
      cnt_nxt = tick ? '0 : cnt_p0 + 1'b1;
      if (tick && (out_nxt == goal_p0))
        state_nxt = (accept && (goal_in != out_nxt)) ? SLEW : IDLE;
    end
  end

  // Registered stage: output code, goal, control and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0   <= IDLE;
      cnt_p0     <= '0;
      goal_p0    <= MIDSCALE;
      out_p0     <= MIDSCALE;
      upd_p0     <= 1'b0;
      settled_p0 <= 1'b1;
    end else begin
      state_p0   <= state_nxt;
      cnt_p0     <= cnt_nxt;
      goal_p0    <= goal_nxt;
      out_p0     <= out_nxt;
      upd_p0     <= (out_nxt != out_p0);
      settled_p0 <= (state_nxt == IDLE) && (out_nxt == goal_nxt);
    end
  end

endmodule

// File: tb/tb_dac_slew_limiter.sv
// Randomized bench for dac_slew_limiter against a tick-schedule reference model,
// plus directed scenarios for slew, clamp, retarget, edge settings and reset.
module tb_dac_slew_limiter;
  localparam int W   = 14;
  localparam int DW  = 16;
  localparam int MID = 32'h2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0]  max_step;
  logic [W-1:0]  lim_lo;
  logic [W-1:0]  lim_hi;
  logic [DW-1:0] tick_div;

  always #5 clk = ~clk;

  dac_slew_if #(.WIRE_WIDTH(W)) bus ();

  dac_slew_limiter #(.WIRE_WIDTH(W), .DIV_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .max_step (max_step),
    .tick_div (tick_div),
    .lim_lo   (lim_lo),
    .lim_hi   (lim_hi)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int upd_cnt = 0;
  int max_out = 0;

  // Reference state: output code, goal, slewing flag and absolute cycle of the next tick.
  int m_out  = MID;
  int m_goal = MID;
  int m_slew = 0;
  int m_next = 0;
  int m_upd  = 0;
  int m_set  = 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int clamp_ref(input int t, input int lo, input int hi);
    if (lo > hi) return lo;
    if (t < lo)  return lo;
    if (t > hi)  return hi;
    return t;
  endfunction

  task automatic step_cycle();
    int st, nout, d, g;
    bit tk, v;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_out = MID; m_goal = MID; m_slew = 0; m_upd = 0; m_set = 1;
    end else begin
      st   = (max_step == 0) ? 1 : int'(max_step);
      v    = bus.target_valid;
      tk   = (m_slew != 0) && (cyc == m_next);
      nout = m_out;
      if (tk) begin
        d = m_goal - m_out;
        if (d >= -st && d <= st) nout = m_goal;
        else nout = (d > 0) ? m_out + st : m_out - st;
      end
      g = v ? clamp_ref(int'(bus.target_in), int'(lim_lo), int'(lim_hi)) : m_goal;
      m_upd = (nout != m_out) ? 1 : 0;
      if (m_slew == 0) begin
        if (v && g != m_out) begin
          m_slew = 1;
          m_next = cyc + int'(tick_div) + 1;
        end
      end else if (tk) begin
        if (nout == m_goal && !(v && g != nout)) m_slew = 0;
        m_next = cyc + int'(tick_div) + 1;
      end
      m_out  = nout;
      m_goal = g;
      m_set  = (m_slew == 0 && m_out == m_goal) ? 1 : 0;
    end
    #1;
    check_eq("data_out", int'(bus.data_out), m_out);
    check_eq("update", int'(bus.update), m_upd);
    check_eq("settled", int'(bus.settled), m_set);
    check_eq("target_ready", int'(bus.target_ready), rst ? 0 : 1);
    if (bus.update) upd_cnt++;
    if (int'(bus.data_out) > max_out) max_out = int'(bus.data_out);
    bus.target_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic accept(input int tgt);
    bus.target_valid = 1'b1;
    bus.target_in    = W'(tgt);
    step_cycle();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    run(n);
    rst = 1'b0;
  endtask

  initial begin
    bus.target_valid = 1'b0;
    bus.target_in    = '0;
    max_step = W'(16'h0100);
    tick_div = DW'(3);
    lim_lo   = '0;
    lim_hi   = W'(16'h3FFF);

    do_reset(2);
    run(1);
    check_eq("reset_data_out", int'(bus.data_out), 32'h2000);
    check_eq("reset_settled", int'(bus.settled), 1);
    check_eq("reset_ready", int'(bus.target_ready), 1);

    // Slew up by three full steps.
    upd_cnt = 0;
    accept(32'h2300);
    run(14);
    check_eq("slew_up_final", int'(bus.data_out), 32'h2300);
    check_eq("slew_up_settled", int'(bus.settled), 1);
    check_eq("slew_up_pulses", upd_cnt, 3);

    // Clamp against lim_hi with a final partial step.
    do_reset(1);
    lim_hi = W'(16'h2180);
    accept(32'h3FFF);
    run(10);
    check_eq("clamp_final", int'(bus.data_out), 32'h2180);

    // Retarget downward mid-climb.
    do_reset(1);
    lim_hi = W'(16'h3FFF);
    max_out = 0;
    accept(32'h2300);
    begin
      int k;
      k = 0;
      while (bus.data_out != W'(16'h2100) && k < 20) begin
        step_cycle();
        k++;
      end
      check_eq("retarget_reach_2100", (k < 20) ? 1 : 0, 1);
    end
    accept(32'h1F00);
    run(20);
    check_eq("retarget_final", int'(bus.data_out), 32'h1F00);
    check_eq("retarget_no_overshoot", (max_out <= 32'h2200) ? 1 : 0, 1);

    // max_step=0 acts as 1, tick_div=0 ticks every cycle.
    rst = 1'b1;
    max_step = '0;
    tick_div = '0;
    run(1);
    rst = 1'b0;
    accept(32'h2003);
    run(4);
    check_eq("unit_step_final", int'(bus.data_out), 32'h2003);
    upd_cnt = 0;
    accept(32'h2003);
    run(2);
    check_eq("same_target_no_update", upd_cnt, 0);
    check_eq("same_target_settled", int'(bus.settled), 1);

    // Reset in the middle of a slew.
    rst = 1'b1;
    max_step = W'(16'h0100);
    tick_div = DW'(3);
    run(1);
    rst = 1'b0;
    accept(32'h3000);
    run(6);
    rst = 1'b1;
    step_cycle();
    check_eq("mid_slew_reset", int'(bus.data_out), 32'h2000);
    rst = 1'b0;

    // Inverted limits clamp to lim_lo.
    lim_lo = W'(16'h3000);
    lim_hi = W'(16'h1000);
    accept(0);
    run(80);
    check_eq("inverted_limits", int'(bus.data_out), 32'h3000);

    // Randomized epochs; tick_div only changes while in reset.
    for (int e = 0; e < 40; e++) begin
      rst = 1'b1;
      tick_div = DW'($urandom_range(0, 5));
      max_step = W'($urandom_range(0, 16'h0400));
      run(1);
      rst = 1'b0;
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 19) == 0) begin
          lim_lo = W'($urandom_range(0, 16'h3FFF));
          lim_hi = W'($urandom_range(0, 16'h3FFF));
        end
        if ($urandom_range(0, 29) == 0) max_step = W'($urandom_range(0, 16'h0400));
        if ($urandom_range(0, 7) == 0) accept(int'($urandom_range(0, 16'h3FFF)));
        else step_cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_slew_limiter.md
Name: dac_slew_limiter

Overview:
- Rate-limiting register stage directly upstream of DAC_offset_to_twos.
- Accepts target codes in offset binary from the SPGD controller and clamps them to a programmable window.
- Moves a registered output toward the clamped target by at most max_step per update tick, so the DAC never jumps.
- data_out feeds DAC_offset_to_twos.data_in unchanged; both are WIRE_WIDTH offset-binary codes.

Parameters:
- WIRE_WIDTH, 14, code width of all data/limit/step ports.
- DIV_WIDTH, 16, width of tick divider.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- target_in  input  WIRE_WIDTH  requested code, offset binary.
- target_valid  input  1  target_in is valid this cycle.
- target_ready  output  1  block accepts a target this cycle.
- max_step  input  WIRE_WIDTH  largest code change per tick; 0 is treated as 1.
- tick_div  input  DIV_WIDTH  tick period minus 1, in clk cycles.
- lim_lo  input  WIRE_WIDTH  lowest allowed code.
- lim_hi  input  WIRE_WIDTH  highest allowed code.
- data_out  output  WIRE_WIDTH  registered output code, offset binary.
- update  output  1  one-cycle pulse in the cycle data_out takes a new value.
- settled  output  1  data_out equals the accepted goal and no slew is in progress.

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - data_out = 2^(WIRE_WIDTH-1) (0x2000, midscale/0 V); goal = same.
  - state = IDLE; tick counter = 0; update = 0; settled = 1; target_ready = 0 while rst is high.
  - Reset wins over any simultaneous target or tick. Reset mid-slew discards the goal and returns data_out to midscale on the next edge.
- Handshake:
  - target_ready = 1 in every cycle rst is low, in both IDLE and SLEW.
  - Acceptance = target_valid & target_ready at a clk edge. A new target during SLEW replaces the goal immediately; the latest target always wins.
- Clamp at acceptance (unsigned compare):
  - goal = lim_lo if target_in < lim_lo.
  - goal = lim_hi if target_in > lim_hi.
  - Otherwise goal = target_in.
  - If lim_lo > lim_hi, goal = lim_lo.
  - Later limit changes do not re-clamp an already stored goal.
- States:
  - IDLE: on acceptance with clamped goal != data_out -> SLEW, tick counter cleared to 0. On acceptance with goal == data_out -> stay in IDLE, no update pulse.
  - SLEW: the counter increments each cycle. When counter == tick_div, a tick occurs and the counter returns to 0. tick_div = 0 -> tick every cycle.
  - An acceptance in SLEW does not restart the counter.
- On tick:
  - d = goal - data_out, computed as (WIRE_WIDTH+1)-bit signed.
  - If |d| <= step (step = max(max_step,1)), data_out = goal, and the state goes to IDLE next cycle.
  - Else data_out = data_out + step when d > 0, or data_out - step when d < 0.
  - No wrap-around is possible, since the result always lies between the old data_out and goal.
  - update = 1 in the cycle after the edge that changed data_out.
- Simultaneous acceptance and tick in the same cycle: the tick uses the old goal; the new goal takes effect from the next cycle.
- settled is registered: 1 exactly when state == IDLE and data_out == goal. It drops in the cycle after an acceptance that enters SLEW.
- Latency: first step appears tick_div+1 cycles after the acceptance edge; each subsequent step follows tick_div+1 cycles later.

Test Plan:
- Reset: rst high 2 cycles, then low -> data_out=0x2000, settled=1, update=0, target_ready=1.
- Slew up: lim 0x0000..0x3FFF, max_step=0x0100, tick_div=3; accept 0x2300.
  - data_out = 0x2100, 0x2200, 0x2300, one step every 4 cycles, with update pulses.
  - settled=1 after 0x2300.
- Clamp and final partial step: lim_hi=0x2180, accept 0x3FFF with max_step=0x0100 from 0x2000.
  - goal=0x2180; data_out = 0x2100, then 0x2180.
- Retarget mid-slew: during the climb of the slew-up scenario at data_out=0x2100, accept 0x1F00.
  - Next ticks: 0x2000, 0x1F00; no overshoot beyond 0x2200.
- Edge settings: max_step=0, tick_div=0, accept 0x2003 -> data_out increments by 1 every cycle to 0x2003. Then accept 0x2003 again -> no update pulse, settled stays 1.
- Reset mid-slew and inverted limits:
  - rst during a slew -> data_out=0x2000 on the next edge.
  - lim_lo=0x3000, lim_hi=0x1000, accept 0x0000 -> goal=0x3000.
